// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_tx_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // Bits above DATA_BITS arrive zero-extended, so they never disturb the XOR.
  function automatic logic calc_parity(input logic [8:0] word, input int mode);
    case (mode)
      PARITY_EVEN: return ^word;
      PARITY_ODD:  return ~^word;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_buffered_if.sv
// Push-side handshake bundle for uart_tx_buffered (word source to transmitter).
interface uart_tx_buffered_if #(
  parameter int WIDTH = 8
);
  // valid/ready: a word is taken on a clk edge where in_valid && in_ready.
  // A word offered while in_ready is low is dropped, not held; in_data is
  // only sampled on an accepting edge.
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with show-ahead read data; pushes while full are dropped.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         din_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// FIFO-buffered UART transmitter: start, DATA_BITS LSB first, optional parity, stop.
// Optional flow control: define UART_TX_CTS_EN to add the cts_n input.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLK_FREQ    = 50000000,
  parameter int BAUD_RATE   = 9600,
  parameter int DATA_BITS   = 8,
  parameter int STOP_BITS   = 1,
  parameter int PARITY_MODE = 0,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                          clk,
  input  logic                          reset,
`ifdef UART_TX_CTS_EN
  input  logic                          cts_n,
`endif
  input  logic [DATA_BITS-1:0]          in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          fifo_empty,
  output logic                          fifo_full,
  output uart_tx_state_t                dbg_state_o
);
  localparam int DIV = CLK_FREQ / BAUD_RATE;
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [TW-1:0] DIV_LAST  = TW'(DIV - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
  localparam bit            HAS_PAR   = (PARITY_MODE != PARITY_NONE);

  uart_tx_state_t       state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 pop;
  logic                 cts_ok;
  logic                 start_ok;
  logic                 bit_end;
  logic [DATA_BITS-1:0] fifo_dout;

`ifdef UART_TX_CTS_EN
  logic [1:0] cts_sync_q;
  // Resets to "not clear" so nothing starts before the line is sampled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cts_sync_q <= 2'b11;
    else        cts_sync_q <= {cts_sync_q[0], cts_n};
  end
  assign cts_ok = !cts_sync_q[1];
`else
  assign cts_ok = 1'b1;
`endif

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (in_valid),
    .pop_i   (pop),
    .din_i   (in_data),
    .dout_o  (fifo_dout),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign in_ready    = !fifo_full;
  assign tx          = tx_q;
  assign busy        = (state_q != IDLE);
  assign dbg_state_o = state_q;
  assign start_ok    = !fifo_empty && cts_ok;
  assign bit_end     = (timer_q == DIV_LAST);

  always_comb begin
    state_d   = state_q;
    timer_d   = bit_end ? '0 : timer_q + 1'b1;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    tx_d      = tx_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        tx_d    = 1'b1;
        if (start_ok) begin
          state_d = START;
          pop     = 1'b1;
          shift_d = fifo_dout;
          par_d   = calc_parity(9'(fifo_dout), PARITY_MODE);
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d   = DATA;
          bit_cnt_d = '0;
          tx_d      = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_cnt_q == DATA_LAST) begin
            bit_cnt_d = '0;
            if (HAS_PAR) begin
              state_d = PARITY;
              tx_d    = par_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            shift_d   = {1'b0, shift_q[DATA_BITS-1:1]};
            tx_d      = shift_d[0];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d   = STOP;
          bit_cnt_d = '0;
          tx_d      = 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (bit_cnt_q == STOP_LAST) begin
            bit_cnt_d = '0;
            // Chaining straight into START keeps consecutive frames gap-free.
            if (start_ok) begin
              state_d = START;
              pop     = 1'b1;
              shift_d = fifo_dout;
              par_d   = calc_parity(9'(fifo_dout), PARITY_MODE);
              tx_d    = 1'b0;
            end else begin
              state_d = IDLE;
              tx_d    = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      tx_q      <= tx_d;
    end
  end

endmodule

// File: doc/uart_tx_buffered.md
UART_TX_BUFFERED -- requirements
Module: uart_tx_buffered

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50000000, clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 9600, line rate in bit/s.
REQ-003 SHALL have parameter DATA_BITS, default 8, data bits per frame, legal 5..9.
REQ-004 SHALL have parameter STOP_BITS, default 1, stop bits per frame, legal 1..2.
REQ-005 SHALL have parameter PARITY_MODE, default 0, parity mode: 0 none, 1 even, 2 odd.
REQ-006 SHALL have parameter FIFO_DEPTH, default 16, entries in the transmit buffer, power of 2, minimum 2.
REQ-007 SHALL have port clk, input, 1 bit, the single clock.
REQ-008 SHALL have port reset, input, 1 bit, asynchronous active-low reset.
REQ-009 SHALL have port in_data, input, DATA_BITS bits, the word to transmit.
REQ-010 SHALL have port in_valid, input, 1 bit, which requests a push of in_data.
REQ-011 SHALL have port in_ready, output, 1 bit, driven as !fifo_full.
REQ-012 SHALL have port tx, output, 1 bit, the serial line, idle high.
REQ-013 SHALL have port busy, output, 1 bit, high while a frame is on the line.
REQ-014 SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1 bits, holding the buffered word count.
REQ-015 SHALL have port fifo_empty, output, 1 bit, buffer empty flag.
REQ-016 SHALL have port fifo_full, output, 1 bit, buffer full flag.

Function
REQ-017 SHALL set the bit period DIV = CLK_FREQ/BAUD_RATE (integer division) clk cycles, counted by an internal timer that restarts at each frame start, so every bit lasts exactly DIV cycles.
REQ-018 SHALL accept a push on a clk edge with in_valid && in_ready; a push while full SHALL be ignored and lose no stored data.
REQ-019 SHALL use states IDLE, START, DATA, PARITY, STOP; IDLE->START when the FIFO is non-empty, START->DATA after 1 bit period, DATA->PARITY (PARITY_MODE!=0) or DATA->STOP after DATA_BITS bit periods, PARITY->STOP after 1 bit period, STOP->START (FIFO non-empty) or STOP->IDLE after STOP_BITS bit periods.
REQ-020 SHALL pop the FIFO on the same edge as IDLE->START or STOP->START; the popped word is held in a shift register and sent LSB first.
REQ-021 SHALL register tx: 0 in START, the data bit in DATA, the parity bit in PARITY, 1 in STOP and IDLE.
REQ-022 SHALL compute the parity bit as ^word for even parity and ~^word for odd parity, over DATA_BITS bits.
REQ-023 SHALL have a latency of 1 clk: after a push into an empty FIFO at edge k with state IDLE, tx falls at edge k+1.
REQ-024 SHALL send back-to-back frames with no idle gap between the last stop bit and the next start bit.
REQ-025 SHALL leave fifo_count unchanged on a simultaneous push and pop; a push while empty and idle still counts and pops normally.
REQ-026 SHALL assert busy from the START entry edge through the end of the final STOP bit, and deassert it only on STOP->IDLE.
REQ-027 SHALL leave in_data and in_valid changes mid-frame without effect on the frame on the line.

Reset
REQ-028 SHALL on reset low immediately force tx=1, busy=0, state IDLE, FIFO flushed (fifo_count=0, fifo_empty=1, fifo_full=0, in_ready=1), timer and bit counter 0.
REQ-029 SHALL on reset mid-frame abort the frame with no completion; the first frame after release starts only on a new push.

Configuration
REQ-030 SHALL, with macro UART_TX_CTS_EN defined, add port cts_n, input, 1 bit, asynchronous to clk, active-low clear-to-send, passed through a 2-flop synchroniser inside the block.
REQ-031 SHALL, with UART_TX_CTS_EN defined, make IDLE->START and STOP->START additionally require synchronised cts_n==0; cts_n going high mid-frame SHALL NOT abort or stretch the frame.
REQ-032 SHALL, without UART_TX_CTS_EN, have no cts_n port, and frames start whenever the FIFO is non-empty.

Structure
REQ-033 SHALL place the state enum type uart_tx_state_t and the PARITY_NONE/EVEN/ODD constants in shared package uart_pkg.
REQ-034 SHALL implement the buffer as sub-module uart_sync_fifo, parametrised by WIDTH and DEPTH, with push, pop, count, full and empty; the FSM, timer and shifter stay in uart_tx_buffered.

Verification (CLK_FREQ=1600000, BAUD_RATE=100000, so DIV=16)
REQ-035 SHALL cover: 8N1, push 0xA5 while idle -> tx low 1 clk after the push, then bits 1,0,1,0,0,1,0,1, then stop, with each bit exactly 16 clk and busy high for 160 clk.
REQ-036 SHALL cover: PARITY_MODE=2 with DATA_BITS=7, push 0x55 -> parity bit 1 (four ones); with PARITY_MODE=1 -> parity bit 0.
REQ-037 SHALL cover: FIFO_DEPTH=4, hold in_valid for 6 pushes while idle -> first pops at once, 4 buffered, in_ready=0 with fifo_full=1, the sixth push is dropped, then 5 back-to-back frames with no idle gap.
REQ-038 SHALL cover: STOP_BITS=2, push 0xFF -> tx high for 32 clk after the last data bit before busy falls.
REQ-039 SHALL cover: reset low at clk 40 of a frame with 3 words buffered -> tx=1 and fifo_count=0 immediately, and no frame after release until a new push.
REQ-040 SHALL cover: UART_TX_CTS_EN defined, cts_n=1, push 0x3C -> tx stays high; cts_n falls -> start bit within 3 clk; cts_n rises mid-frame -> frame completes unchanged.
